id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage_pkg.sv | 45 ++++
 rtl/id_decoder.sv | 67 ++++++
 rtl/id_stage.sv | 137 +++++++++++++
 tb/tb_id_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// Shared decode constants for the ID stage:
// opcodes, control words and control-field positions.
package id_stage_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [11:0] CTRL_NOP  = 12'b000000000000;
    localparam logic [11:0] CTRL_ADD  = 12'b000100000000;
    localparam logic [11:0] CTRL_SUB  = 12'b000100000010;
    localparam logic [11:0] CTRL_AND  = 12'b000100000100;
    localparam logic [11:0] CTRL_OR   = 12'b000100000110;
    localparam logic [11:0] CTRL_SLL  = 12'b000100001000;
    localparam logic [11:0] CTRL_SLT  = 12'b000100001010;
    localparam logic [11:0] CTRL_ADDI = 12'b000100000001;
    localparam logic [11:0] CTRL_LD   = 12'b000101100001;
    localparam logic [11:0] CTRL_SD   = 12'b000000010001;
    localparam logic [11:0] CTRL_BR   = 12'b100000000000;
    localparam logic [11:0] CTRL_JAL  = 12'b010110000000;
    localparam logic [11:0] CTRL_JALR = 12'b001110000000;

    localparam int CB_BRANCH = 11;
    localparam int CB_JAL    = 10;
    localparam int CB_JALR   = 9;
    localparam int CB_REGWR  = 8;
    localparam int CB_LINK   = 7;
    localparam int CB_MEM2R  = 6;
    localparam int CB_MEMRD  = 5;
    localparam int CB_MEMWR  = 4;
    localparam int CB_ALUSRC = 0;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/id_decoder.sv
// Instruction decoder: control word from opcode/funct
// fields plus sign-extended immediate generation.
module id_decoder
    import id_stage_pkg::*;
(
    input  logic [31:0] inst,
    output logic [11:0] ctrl,
    output logic [31:0] imm
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    always_comb begin
        ctrl = CTRL_NOP;
        imm  = 32'd0;
        unique case (opcode)
            OP_R: begin
                unique case ({funct7, funct3})
                    {F7_BASE, 3'b000}: ctrl = CTRL_ADD;
                    {F7_ALT,  3'b000}: ctrl = CTRL_SUB;
                    {F7_BASE, 3'b001}: ctrl = CTRL_SLL;
                    {F7_BASE, 3'b010}: ctrl = CTRL_SLT;
                    {F7_BASE, 3'b111}: ctrl = CTRL_AND;
                    {F7_BASE, 3'b110}: ctrl = CTRL_OR;
                    default:           ctrl = CTRL_NOP;
                endcase
            end
            OP_ADDI: begin
                ctrl = CTRL_ADDI;
                imm  = {{20{inst[31]}}, inst[31:20]};
            end
            OP_LD: begin
                ctrl = CTRL_LD;
                imm  = {{20{inst[31]}}, inst[31:20]};
            end
            OP_JALR: begin
                ctrl = CTRL_JALR;
                imm  = {{20{inst[31]}}, inst[31:20]};
            end
            OP_SD: begin
                ctrl = CTRL_SD;
                imm  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_BR: begin
                ctrl = CTRL_BR;
                imm  = {{20{inst[31]}}, inst[7], inst[30:25],
                        inst[11:8], 1'b0};
            end
            OP_JAL: begin
                ctrl = CTRL_JAL;
                imm  = {{12{inst[31]}}, inst[19:12], inst[20],
                        inst[30:21], 1'b0};
            end
            default: begin
                ctrl = CTRL_NOP;
                imm  = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: operand read with write-first bypass,
// jump/branch resolution and the ID/EX pipeline register.
module id_stage
    import id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        op_write,
    input  logic [31:0] pipe_pc,
    input  logic [31:0] pipe_pc4,
    input  logic [31:0] pipe_data,
    input  logic [31:0] write_data,
    input  logic [31:0] write_addr,
    input  logic [31:0] load_pc_reg_value1,
    input  logic [31:0] load_pc_reg_value2,
    output logic        control_j,
    output logic [31:0] pc_j,
    output logic [8:0]  ctrl_ex,
    output logic [31:0] pc4_ex,
    output logic [31:0] r_data1,
    output logic [31:0] r_data2,
    output logic [31:0] extended,
    output logic [31:0] rd_ex,
    output logic [31:0] load_pc_reg_addr1,
    output logic [31:0] load_pc_reg_addr2,
    output logic [31:0] write_pc_reg_addr,
    output logic [31:0] write_pc_reg_value
);

    logic [11:0] ctrl;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  wa;
    logic        wr_en;
    logic [31:0] r_value1;
    logic [31:0] r_value2;
    logic        taken;

    logic [8:0]  ctrl_d,  ctrl_q;
    logic [31:0] pc4_d,   pc4_q;
    logic [31:0] r1_d,    r1_q;
    logic [31:0] r2_d,    r2_q;
    logic [31:0] imm_d,   imm_q;
    logic [4:0]  rd_d,    rd_q;

    id_decoder u_dec (
        .inst (pipe_data),
        .ctrl (ctrl),
        .imm  (imm)
    );

    assign rs1   = pipe_data[19:15];
    assign rs2   = pipe_data[24:20];
    assign wa    = write_addr[4:0];
    assign wr_en = op_write && (wa != 5'd0);

    assign load_pc_reg_addr1  = {27'd0, rs1};
    assign load_pc_reg_addr2  = {27'd0, rs2};
    assign write_pc_reg_addr  = wr_en ? write_addr : 32'd0;
    assign write_pc_reg_value = wr_en ? write_data : 32'd0;

    // The WB write lands this cycle, so a matching read sees it.
    always_comb begin
        r_value1 = load_pc_reg_value1;
        r_value2 = load_pc_reg_value2;
        if (rs1 == 5'd0)
            r_value1 = 32'd0;
        else if (wr_en && wa == rs1)
            r_value1 = write_data;
        if (rs2 == 5'd0)
            r_value2 = 32'd0;
        else if (wr_en && wa == rs2)
            r_value2 = write_data;
    end

    always_comb begin
        taken = 1'b0;
        unique case (pipe_data[14:12])
            F3_BEQ:  taken = (r_value1 == r_value2);
            F3_BNE:  taken = (r_value1 != r_value2);
            F3_BLT:  taken = ($signed(r_value1) < $signed(r_value2));
            F3_BGE:  taken = ($signed(r_value1) >= $signed(r_value2));
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        control_j = 1'b0;
        pc_j      = 32'd0;
        if (ctrl[CB_JAL]) begin
            control_j = 1'b1;
            pc_j      = pipe_pc + imm;
        end else if (ctrl[CB_JALR]) begin
            control_j = 1'b1;
            pc_j      = (r_value1 + imm) & 32'hFFFF_FFFE;
        end else if (ctrl[CB_BRANCH] && taken) begin
            control_j = 1'b1;
            pc_j      = pipe_pc + imm;
        end
    end

    always_comb begin
        ctrl_d = ctrl[8:0];
        pc4_d  = pipe_pc4;
        r1_d   = r_value1;
        r2_d   = r_value2;
        imm_d  = imm;
        rd_d   = pipe_data[11:7];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= 9'd0;
            pc4_q  <= 32'd0;
            r1_q   <= 32'd0;
            r2_q   <= 32'd0;
            imm_q  <= 32'd0;
            rd_q   <= 5'd0;
        end else begin
            ctrl_q <= ctrl_d;
            pc4_q  <= pc4_d;
            r1_q   <= r1_d;
            r2_q   <= r2_d;
            imm_q  <= imm_d;
            rd_q   <= rd_d;
        end
    end

    assign ctrl_ex  = ctrl_q;
    assign pc4_ex   = pc4_q;
    assign r_data1  = r1_q;
    assign r_data2  = r2_q;
    assign extended = imm_q;
    assign rd_ex    = {27'd0, rd_q};

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-encoded instructions
// with hand-computed decode, jump and register results.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_write;
    logic [31:0] pipe_pc, pipe_pc4, pipe_data;
    logic [31:0] write_data, write_addr;
    logic [31:0] load_pc_reg_value1, load_pc_reg_value2;
    logic        control_j;
    logic [31:0] pc_j;
    logic [8:0]  ctrl_ex;
    logic [31:0] pc4_ex, r_data1, r_data2, extended, rd_ex;
    logic [31:0] load_pc_reg_addr1, load_pc_reg_addr2;
    logic [31:0] write_pc_reg_addr, write_pc_reg_value;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk                (clk),
        .reset              (reset),
        .op_write           (op_write),
        .pipe_pc            (pipe_pc),
        .pipe_pc4           (pipe_pc4),
        .pipe_data          (pipe_data),
        .write_data         (write_data),
        .write_addr         (write_addr),
        .load_pc_reg_value1 (load_pc_reg_value1),
        .load_pc_reg_value2 (load_pc_reg_value2),
        .control_j          (control_j),
        .pc_j               (pc_j),
        .ctrl_ex            (ctrl_ex),
        .pc4_ex             (pc4_ex),
        .r_data1            (r_data1),
        .r_data2            (r_data2),
        .extended           (extended),
        .rd_ex              (rd_ex),
        .load_pc_reg_addr1  (load_pc_reg_addr1),
        .load_pc_reg_addr2  (load_pc_reg_addr2),
        .write_pc_reg_addr  (write_pc_reg_addr),
        .write_pc_reg_value (write_pc_reg_value)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        op_write = 1'b0;
        pipe_pc = 0; pipe_pc4 = 0; pipe_data = 0;
        write_data = 0; write_addr = 0;
        load_pc_reg_value1 = 0; load_pc_reg_value2 = 0;
        tick();
        chk("rst_ctrl", {23'd0, ctrl_ex}, 32'd0);
        chk("rst_pc4", pc4_ex, 32'd0);
        chk("rst_r1", r_data1, 32'd0);
        chk("rst_r2", r_data2, 32'd0);
        chk("rst_ext", extended, 32'd0);
        chk("rst_rd", rd_ex, 32'd0);
        reset = 1'b0;

        // ADDI x12,x20,7
        pipe_pc = 400; pipe_pc4 = 404; pipe_data = 32'h007A0613;
        load_pc_reg_value1 = 8;
        #1;
        chk("addi_a1", load_pc_reg_addr1, 32'd20);
        chk("addi_cj", {31'd0, control_j}, 32'd0);
        chk("addi_pcj", pc_j, 32'd0);
        tick();
        chk("addi_ctrl", {23'd0, ctrl_ex}, 32'h101);
        chk("addi_pc4", pc4_ex, 32'd404);
        chk("addi_r1", r_data1, 32'd8);
        chk("addi_ext", extended, 32'd7);
        chk("addi_rd", rd_ex, 32'd12);

        // JAL x1,+16
        pipe_pc = 100; pipe_pc4 = 104; pipe_data = 32'h010000EF;
        #1;
        chk("jal_cj", {31'd0, control_j}, 32'd1);
        chk("jal_pcj", pc_j, 32'd116);
        tick();
        chk("jal_ctrl", {23'd0, ctrl_ex}, 32'h180);
        chk("jal_pc4", pc4_ex, 32'd104);
        chk("jal_rd", rd_ex, 32'd1);

        // BEQ x1,x2,-8
        pipe_pc = 200; pipe_pc4 = 204; pipe_data = 32'hFE208CE3;
        load_pc_reg_value1 = 5; load_pc_reg_value2 = 5;
        #1;
        chk("beq_a2", load_pc_reg_addr2, 32'd2);
        chk("beq_t_cj", {31'd0, control_j}, 32'd1);
        chk("beq_t_pcj", pc_j, 32'd192);
        load_pc_reg_value2 = 6;
        #1;
        chk("beq_nt_cj", {31'd0, control_j}, 32'd0);
        chk("beq_nt_pcj", pc_j, 32'd0);

        // BLT x1,x2,-8 with -1 < 1
        pipe_data = 32'hFE20CCE3;
        load_pc_reg_value1 = 32'hFFFFFFFF; load_pc_reg_value2 = 1;
        #1;
        chk("blt_cj", {31'd0, control_j}, 32'd1);
        chk("blt_pcj", pc_j, 32'd192);
        tick();
        chk("blt_ctrl", {23'd0, ctrl_ex}, 32'd0);
        chk("blt_ext", extended, 32'hFFFFFFF8);
        chk("blt_r1", r_data1, 32'hFFFFFFFF);
        chk("blt_r2", r_data2, 32'd1);

        // SUB x3,x1,x2 with bypass on x1
        pipe_pc = 300; pipe_pc4 = 304; pipe_data = 32'h402081B3;
        op_write = 1'b1; write_addr = 1; write_data = 77;
        load_pc_reg_value1 = 3; load_pc_reg_value2 = 4;
        #1;
        chk("sub_wpa", write_pc_reg_addr, 32'd1);
        chk("sub_wpv", write_pc_reg_value, 32'd77);
        tick();
        chk("sub_r1", r_data1, 32'd77);
        chk("sub_r2", r_data2, 32'd4);
        chk("sub_ctrl", {23'd0, ctrl_ex}, 32'h102);
        chk("sub_rd", rd_ex, 32'd3);
        chk("sub_ext", extended, 32'd0);

        // JALR x1,9(x5)
        op_write = 1'b0; pipe_data = 32'h009280E7;
        load_pc_reg_value1 = 32'h100;
        #1;
        chk("jalr_cj", {31'd0, control_j}, 32'd1);
        chk("jalr_pcj", pc_j, 32'h108);
        tick();
        chk("jalr_ctrl", {23'd0, ctrl_ex}, 32'h180);
        chk("jalr_ext", extended, 32'd9);

        // SD x2,-4(x1)
        pipe_data = 32'hFE20BE23;
        #1;
        chk("sd_cj", {31'd0, control_j}, 32'd0);
        tick();
        chk("sd_ctrl", {23'd0, ctrl_ex}, 32'h011);
        chk("sd_ext", extended, 32'hFFFFFFFC);

        // ADD x5,x0,x2 with a write to x0 pending
        op_write = 1'b1; write_addr = 0; write_data = 9;
        pipe_data = 32'h002002B3; load_pc_reg_value1 = 55;
        #1;
        chk("x0_wpa", write_pc_reg_addr, 32'd0);
        chk("x0_wpv", write_pc_reg_value, 32'd0);
        tick();
        chk("x0_r1", r_data1, 32'd0);
        chk("add_ctrl", {23'd0, ctrl_ex}, 32'h100);
        op_write = 1'b0;

        // R-type with unsupported funct3
        pipe_data = 32'h0020B1B3;
        tick();
        chk("badr_ctrl", {23'd0, ctrl_ex}, 32'd0);

        // Unknown opcode
        pipe_data = 32'hFFFFFFFF;
        #1;
        chk("ill_cj", {31'd0, control_j}, 32'd0);
        tick();
        chk("ill_ctrl", {23'd0, ctrl_ex}, 32'd0);
        chk("ill_ext", extended, 32'd0);

        // Reset mid-stream discards the in-flight ADDI
        pipe_pc = 400; pipe_pc4 = 404; pipe_data = 32'h007A0613;
        load_pc_reg_value1 = 8;
        tick();
        reset = 1'b1;
        #1;
        chk("mrst_a1", load_pc_reg_addr1, 32'd20);
        tick();
        chk("mrst_ctrl", {23'd0, ctrl_ex}, 32'd0);
        chk("mrst_pc4", pc4_ex, 32'd0);
        chk("mrst_r1", r_data1, 32'd0);
        chk("mrst_ext", extended, 32'd0);
        chk("mrst_rd", rd_ex, 32'd0);
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
